// File: rtl/loader_pkg.sv
// Shared state encoding and sizing constants for the program loader.
package loader_pkg;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam int DWIDTH_DEFAULT = 32;
    localparam int BYTES_PER_WORD = DWIDTH_DEFAULT / 8;
    localparam int LEN_BYTES      = 2;

    function automatic int bytes_per_word(input int dw);
        return dw / 8;
    endfunction
endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into DWIDTH-bit words; full flags that
// the next push completes the current word.
module byte_packer
    import loader_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [7:0]        data,
    output logic [DWIDTH-1:0] word,
    output logic              full
);
    localparam int BPW = bytes_per_word(DWIDTH);
    localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [LW-1:0] lane;

    assign full = (lane == LW'(BPW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= '0;
            word <= '0;
        end else if (clear) begin
            lane <= '0;
            word <= '0;
        end else if (push) begin
            word[8*lane +: 8] <= data;
            lane              <= full ? '0 : lane + LW'(1);
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Boot loader: streams a length-prefixed image into instruction memory and
// holds the CPU in reset until the whole image has been written.
module prog_loader
    import loader_pkg::*;
#(
    parameter int MEMORY_AWIDTH = 15,
    parameter int DWIDTH        = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [MEMORY_AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0]        mem_wdata,
    output logic                     cpu_rst,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam logic [32:0] MAX_WORDS = 33'(1) << MEMORY_AWIDTH;

    logic [2:0]             state, state_next;
    logic [MEMORY_AWIDTH:0] word_cnt;
    logic [MEMORY_AWIDTH:0] word_cnt_inc;
    logic [15:0]            n_words;
    logic [15:0]            n_next;
    logic [7:0]             len_lo;
    logic                   len_idx;
    logic                   len_last;
    logic                   xfer;
    logic                   start_ok;
    logic                   pk_full;

    assign xfer         = in_valid && in_ready;
    assign start_ok     = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign n_next       = {in_data, len_lo};
    assign len_last     = (len_idx == 1'(LEN_BYTES - 1));
    assign word_cnt_inc = word_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR:
                if (start) state_next = S_LEN;
            S_LEN:
                if (xfer && len_last) begin
                    if (n_next == 16'd0)                state_next = S_DONE;
                    else if (33'(n_next) > MAX_WORDS)   state_next = S_ERR;
                    else                                state_next = S_LOAD;
                end
            S_LOAD:
                if (xfer && pk_full) state_next = S_WRITE;
            S_WRITE:
                state_next = (33'(word_cnt_inc) == 33'(n_words)) ? S_DONE : S_LOAD;
            default:
                state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == S_LEN) || (state == S_LOAD);
        mem_we   = (state == S_WRITE);
        busy     = (state == S_LEN) || (state == S_LOAD) || (state == S_WRITE);
        done     = (state == S_DONE);
        err      = (state == S_ERR);
        cpu_rst  = (state != S_DONE);
    end

    // mem_addr is latched on entry to WRITE so it still shows the last
    // address after word_cnt steps past the end of memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            n_words  <= '0;
            len_lo   <= '0;
            len_idx  <= 1'b0;
            mem_addr <= '0;
        end else begin
            if (start_ok) begin
                word_cnt <= '0;
                n_words  <= '0;
                len_idx  <= 1'b0;
            end
            if (state == S_LEN && xfer) begin
                if (!len_last) begin
                    len_lo  <= in_data;
                    len_idx <= 1'b1;
                end else begin
                    n_words <= n_next;
                end
            end
            if (state == S_LOAD && xfer && pk_full)
                mem_addr <= word_cnt[MEMORY_AWIDTH-1:0];
            if (state == S_WRITE)
                word_cnt <= word_cnt_inc;
        end
    end

    byte_packer #(.DWIDTH(DWIDTH)) u_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (start_ok),
        .push  ((state == S_LOAD) && xfer),
        .data  (in_data),
        .word  (mem_wdata),
        .full  (pk_full)
    );
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; small MEMORY_AWIDTH keeps the max-size load short.
module tb_prog_loader;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_rst, busy, done, err;

    int tests = 0;
    int fails = 0;

    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];

    prog_loader #(.MEMORY_AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             nb;
        logic [127:0]   bytes;
        int             nw;
        logic [127:0]   words;
        logic           done_e;
        logic           err_e;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            chk("ready_low_in_write", 64'(in_ready), 64'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int  cyc = 0;
        bit  acc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (cyc < 50) begin
            if (in_ready) begin
                @(posedge clk);
                acc = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL byte_timeout: byte %0h not accepted within 50 cycles", b);
        end
    endtask

    task automatic send_queue(input logic [7:0] q[$], input int gapmax);
        for (int i = 0; i < q.size(); i++) begin
            int gap;
            send_byte(q[i]);
            gap = $urandom_range(0, gapmax);
            if (gap > 0 && i < q.size() - 1) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
    endtask

    task automatic start_load();
        wr_addr.delete();
        wr_data.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("start_done_clr", 64'(done), 64'd0);
        chk("start_err_clr", 64'(err), 64'd0);
    endtask

    // Checks the cycle after the last byte and the write log.
    task automatic finish_check(input int nw, input logic [DW-1:0] exp_w[$],
                                input logic done_e, input logic err_e);
        @(negedge clk);
        in_valid = 1'b0;
        if (nw > 0) begin
            chk("we_after_last_byte", 64'(mem_we), 64'd1);
            chk("addr_last_write", 64'(mem_addr), 64'(nw - 1));
            @(negedge clk);
        end
        chk("done", 64'(done), 64'(done_e));
        chk("err", 64'(err), 64'(err_e));
        chk("cpu_rst", 64'(cpu_rst), 64'(!done_e));
        repeat (2) @(negedge clk);
        chk("write_count", 64'(wr_addr.size()), 64'(nw));
        for (int i = 0; i < nw; i++) begin
            if (i < wr_addr.size()) begin
                chk("write_addr", 64'(wr_addr[i]), 64'(i));
                chk("write_data", 64'(wr_data[i]), 64'(exp_w[i]));
            end
        end
    endtask

    initial begin
        logic [7:0]    q[$];
        logic [DW-1:0] ew[$];

        vecs[0] = '{10, 128'hDEADBEEF_12345678_0002, 2, 128'hDEADBEEF_12345678, 1'b1, 1'b0};
        vecs[1] = '{2,  128'h0000, 0, 128'h0, 1'b1, 1'b0};
        vecs[2] = '{2,  128'h8001, 0, 128'h0, 1'b0, 1'b1};
        vecs[3] = '{6,  128'h44332211_0001, 1, 128'h44332211, 1'b1, 1'b0};
        vecs[4] = '{14, 128'h0C0B0A09_08070605_04030201_0003, 3,
                    128'h0C0B0A09_08070605_04030201, 1'b1, 1'b0};
        vecs[5] = '{2,  128'h0011, 0, 128'h0, 1'b0, 1'b1};

        // asynchronous reset between edges
        #3 rst = 1'b1;
        #1;
        chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_ready", 64'(in_ready), 64'd0);

        for (int v = 0; v < 6; v++) begin
            q.delete();
            ew.delete();
            for (int i = 0; i < vecs[v].nb; i++) q.push_back(vecs[v].bytes[8*i +: 8]);
            for (int i = 0; i < vecs[v].nw; i++) ew.push_back(vecs[v].words[32*i +: 32]);
            start_load();
            send_queue(q, v % 2);
            finish_check(vecs[v].nw, ew, vecs[v].done_e, vecs[v].err_e);
        end

        // stalls, valid held through WRITE, and a start pulse ignored mid-LOAD
        start_load();
        q = '{8'h02, 8'h00, 8'h11, 8'h22};
        send_queue(q, 2);
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_busy", 64'(busy), 64'd1);
        chk("start_ignored_ready", 64'(in_ready), 64'd1);
        q = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_queue(q, 0);
        ew = '{32'h44332211, 32'h88776655};
        finish_check(2, ew, 1'b1, 1'b0);

        // largest legal image: 2^AW words, last address all ones
        start_load();
        q = '{8'h10, 8'h00};
        ew.delete();
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++) q.push_back(8'(4*i + k));
            ew.push_back({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
        end
        send_queue(q, 1);
        finish_check(16, ew, 1'b1, 1'b0);

        // reset mid-load, then a fresh load must start at lane 0, address 0
        start_load();
        q = '{8'h01, 8'h00, 8'h11, 8'h22};
        send_queue(q, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        start_load();
        q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_queue(q, 1);
        ew = '{32'hDDCCBBAA};
        finish_check(1, ew, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
